// File: rtl/fu_wb_queue_if.sv
// Handshake bundle between a functional unit, the writeback queue and the
// register-file arbiter. The queue uses the slave view; the environment
// (functional unit plus arbiter) uses the master view.
interface fu_wb_queue_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2048
);
    logic                  enq_valid;
    logic                  enq_ready;
    logic [ADDR_WIDTH-1:0] enq_addr;
    logic [DATA_WIDTH-1:0] enq_data;
    logic [63:0]           enq_exec_mask;

    logic                  queue_entry_valid;
    logic                  queue_entry_serviced;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic [63:0]           out_exec_mask;

    modport master (
        output enq_valid, enq_addr, enq_data, enq_exec_mask, queue_entry_serviced,
        input  enq_ready, queue_entry_valid, out_addr, out_data, out_exec_mask
    );

    modport slave (
        input  enq_valid, enq_addr, enq_data, enq_exec_mask, queue_entry_serviced,
        output enq_ready, queue_entry_valid, out_addr, out_data, out_exec_mask
    );
endinterface

// File: rtl/fu_wb_queue.sv
// Writeback queue between a functional unit and the register-file arbiter.
// In-order FIFO with a registered head entry, so out_* come straight from
// flops, read 0 after reset and keep the last popped entry while empty.
// Handshake outputs depend only on registered state; the arbiter may build
// its grant combinationally from queue_entry_valid without forming a loop.
module fu_wb_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2048
) (
    input  logic                     clk,
    input  logic                     rst,
    fu_wb_queue_if.slave             bus,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow_err,
    output logic                     underflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [63:0]           mask;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    entry_t             enq_entry;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_next;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               head_from_enq;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Full blocks an enqueue regardless of a same-cycle pop: enq_ready must
    // not depend on the grant.
    assign push    = bus.enq_valid && !full;
    assign pop     = bus.queue_entry_serviced && !empty;
    assign rd_next = rd_ptr + PTR_W'(1);

    assign enq_entry = '{addr: bus.enq_addr, data: bus.enq_data, mask: bus.enq_exec_mask};

    // The incoming entry becomes the head directly when the queue is empty,
    // or when the only stored entry is popped in the same cycle.
    assign head_from_enq = push && (empty || (pop && count == CNT_W'(1)));

    assign bus.enq_ready         = !full;
    assign bus.queue_entry_valid = !empty;
    assign bus.out_addr          = head.addr;
    assign bus.out_data          = head.data;
    assign bus.out_exec_mask     = head.mask;
    assign occupancy             = count;

    // Storage array: written on every accepted enqueue at the write pointer.
    // NOTE: the array has no reset; occupancy and the head register decide
    // what is visible, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enq_entry;
        end
    end

    // Pointers, occupancy and sticky error flags; reset wins over traffic.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (bus.enq_valid && full) begin
                overflow_err <= 1'b1;
            end
            if (bus.queue_entry_serviced && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Head register: reloads from the next stored entry on a pop, or from
    // the incoming entry when nothing else is queued; otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
        end else if (pop && count > CNT_W'(1)) begin
            head <= mem[rd_next];
        end else if (head_from_enq) begin
            head <= enq_entry;
        end
    end
endmodule

// File: tb/tb_fu_wb_queue.sv
// Self-checking bench for fu_wb_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_fu_wb_queue;
    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 2048;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [63:0]           mask;
    } ent_t;

    logic                clk;
    logic                rst;
    logic [$clog2(DEPTH):0] occupancy;
    logic                overflow_err;
    logic                underflow_err;

    fu_wb_queue_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    fu_wb_queue #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;

    // Reference model state
    ent_t model_q [$];
    ent_t model_last;
    bit   model_ovf;
    bit   model_unf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DATA_WIDTH-1:0] obs,
                            input logic [DATA_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed low64=0x%0h expected low64=0x%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic ent_t mk(input logic [ADDR_WIDTH-1:0] a);
        ent_t e;
        e.addr = a;
        for (int i = 0; i < DATA_WIDTH / 32; i++) begin
            e.data[i*32 +: 32] = $urandom;
        end
        e.mask = {$urandom, $urandom};
        return e;
    endfunction

    // Behavioural rules applied at each clock edge.
    task automatic model_update(input logic r, input logic v, input ent_t e, input logic g);
        bit was_full;
        bit was_empty;
        if (r) begin
            model_q.delete();
            model_last = '0;
            model_ovf  = 0;
            model_unf  = 0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (v && was_full) model_ovf = 1;
            if (g && was_empty) model_unf = 1;
            if (g && !was_empty) model_last = model_q.pop_front();
            if (v && !was_full) model_q.push_back(e);
        end
    endtask

    task automatic check_all();
        ent_t exp_head;
        exp_head = (model_q.size() != 0) ? model_q[0] : model_last;
        chk("occupancy", 64'(occupancy), 64'(model_q.size()));
        chk("queue_entry_valid", 64'(bus.queue_entry_valid), 64'(model_q.size() != 0));
        chk("enq_ready", 64'(bus.enq_ready), 64'(model_q.size() != DEPTH));
        chk("out_addr", 64'(bus.out_addr), 64'(exp_head.addr));
        chk("out_exec_mask", bus.out_exec_mask, exp_head.mask);
        chk_data("out_data", bus.out_data, exp_head.data);
        chk("overflow_err", 64'(overflow_err), 64'(model_ovf));
        chk("underflow_err", 64'(underflow_err), 64'(model_unf));
    endtask

    // One clock: drive after the falling edge, model at the rising edge,
    // sample 1 time unit later.
    task automatic step(input logic r, input logic v, input ent_t e, input logic g);
        @(negedge clk);
        rst                      = r;
        bus.enq_valid            = v;
        bus.enq_addr             = e.addr;
        bus.enq_data             = e.data;
        bus.enq_exec_mask        = e.mask;
        bus.queue_entry_serviced = g;
        @(posedge clk);
        model_update(r, v, e, g);
        #1;
        check_all();
    endtask

    initial begin
        ent_t                  idle;
        logic [DATA_WIDTH-1:0] held;
        logic                  g;

        idle = '0;
        rst = 1'b1;
        bus.enq_valid = 1'b0;
        bus.enq_addr = '0;
        bus.enq_data = '0;
        bus.enq_exec_mask = '0;
        bus.queue_entry_serviced = 1'b0;
        model_q.delete();
        model_last = '0;
        model_ovf = 0;
        model_unf = 0;

        // Reset state
        step(1, 0, idle, 0);
        step(1, 0, idle, 0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
        chk("rst_out_addr", 64'(bus.out_addr), 64'd0);

        // Three back-to-back enqueues with no grant
        step(0, 1, mk(10'h010), 0);
        chk("first_valid", 64'(bus.queue_entry_valid), 64'd1);
        chk("first_occ", 64'(occupancy), 64'd1);
        chk("first_out_addr", 64'(bus.out_addr), 64'h010);
        step(0, 1, mk(10'h011), 0);
        chk("second_occ", 64'(occupancy), 64'd2);
        step(0, 1, mk(10'h012), 0);
        chk("third_occ", 64'(occupancy), 64'd3);
        chk("third_out_addr", 64'(bus.out_addr), 64'h010);

        // Fill, then overflow attempt with 0x3FF
        step(0, 1, mk(10'h013), 0);
        chk("full_ready", 64'(bus.enq_ready), 64'd0);
        step(0, 1, mk(10'h3FF), 0);
        chk("ovf_flag", 64'(overflow_err), 64'd1);
        chk("ovf_occ", 64'(occupancy), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 64'(bus.out_addr), 64'(10'h010 + 10'(i)));
            step(0, 0, idle, 1);
        end
        chk("drained_occ", 64'(occupancy), 64'd0);
        chk("drained_valid", 64'(bus.queue_entry_valid), 64'd0);
        chk("last_popped_held", 64'(bus.out_addr), 64'h013);

        // Grant while empty
        step(0, 0, idle, 1);
        chk("unf_flag", 64'(underflow_err), 64'd1);
        chk("unf_occ", 64'(occupancy), 64'd0);

        // Steady state at occupancy 2 with enqueue and grant every cycle
        step(1, 0, idle, 0);
        step(0, 1, mk(10'h020), 0);
        step(0, 1, mk(10'h021), 0);
        for (int i = 0; i < 10; i++) begin
            chk("stream_head", 64'(bus.out_addr), 64'(i < 2 ? 10'h020 + 10'(i) : 10'h100 + 10'(i - 2)));
            step(0, 1, mk(10'h100 + 10'(i)), 1);
            chk("stream_occ", 64'(occupancy), 64'd2);
        end

        // Fill and rotate the grant 1,0,1,0 while valid stays high
        step(0, 1, mk(10'h200), 0);
        step(0, 1, mk(10'h201), 0);
        for (int i = 0; i < 6; i++) begin
            held = bus.out_data;
            step(0, 0, idle, (i % 2) == 0);
            if ((i % 2) == 1) begin
                chk_data("rotate_hold", bus.out_data, held);
            end
        end

        // Reset with occupancy 3 and a grant in the same cycle
        step(1, 0, idle, 0);
        step(0, 0, idle, 1);
        step(0, 1, mk(10'h030), 0);
        step(0, 1, mk(10'h031), 0);
        step(0, 1, mk(10'h032), 0);
        chk("pre_rst_occ", 64'(occupancy), 64'd3);
        step(1, 1, mk(10'h033), 1);
        chk("rst_grant_occ", 64'(occupancy), 64'd0);
        chk("rst_grant_valid", 64'(bus.queue_entry_valid), 64'd0);
        chk("rst_grant_ready", 64'(bus.enq_ready), 64'd1);
        chk("rst_grant_unf", 64'(underflow_err), 64'd0);
        chk("rst_grant_ovf", 64'(overflow_err), 64'd0);

        // Random traffic; the grant is mostly a function of queue_entry_valid
        for (int i = 0; i < 400; i++) begin
            if (bus.queue_entry_valid) g = ($urandom_range(0, 2) != 0);
            else                       g = ($urandom_range(0, 15) == 0);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 mk(10'($urandom)), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
